sr_latch_driver: RTL and testbench

Clocked controller that drives the S/R inputs of a cross-coupled NOR SR latch and confirms each write through the latch's Q output.
- Accepts a level request over a valid/ready handshake.
- Issues a fixed-width set or reset pulse, then enforces a guard interval with both inputs low.
- Checks synchronized Q feedback against the requested level and reports done, or err on timeout.
- Sits between synchronous control logic and any asynchronous gate-level latch instance.

---
 rtl/sr_latch_driver.sv | 110 +++++++++++
 tb/tb_sr_latch_driver.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives S/R of a NOR latch and confirms each write via synchronized Q; SR_INIT_CLEAR_EN adds a clearing write after reset
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int GUARD_W = 2,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  output logic lvl,
  output logic busy,
  output logic done,
  output logic err
);
  typedef enum logic [1:0] {IDLE, PULSE, GUARD, CHECK} state_t;
  localparam logic [CNT_W-1:0] P_END = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] G_END = CNT_W'(GUARD_W - 1);
  localparam logic [CNT_W-1:0] T_END = CNT_W'(TIMEOUT);
`ifdef SR_INIT_CLEAR_EN
  localparam logic INIT_RST = 1'b1;
`else
  localparam logic INIT_RST = 1'b0;
`endif
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic level, level_d, init, init_d, sync1;
  logic s_d, r_d, done_d, err_d;
  // next state, counter and registered-output values
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    level_d = level;
    init_d  = init;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (init) begin
          state_d = PULSE;
          level_d = 1'b0;
          init_d  = 1'b0;
        end else if (req_valid && req_ready) begin
          state_d = PULSE;
          level_d = req_level;
        end
      end
      PULSE: if (cnt == P_END) begin
        state_d = GUARD;
        cnt_d   = '0;
      end
      GUARD: if (cnt == G_END) begin
        state_d = CHECK;
        cnt_d   = '0;
      end
      CHECK: if (lvl == level) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (cnt == T_END) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    s_d = (state_d == PULSE) && level_d;
    r_d = (state_d == PULSE) && !level_d;
  end
  // state and registered outputs; reset drops S/R immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      level     <= 1'b0;
      init      <= INIT_RST;
      S         <= 1'b0;
      R         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      level     <= level_d;
      init      <= init_d;
      S         <= s_d;
      R         <= r_d;
      done      <= done_d;
      err       <= err_d;
      busy      <= state_d != IDLE;
      req_ready <= (state_d == IDLE) && !init_d;
    end
  end
  // two-flop synchronizer for the asynchronous latch output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      lvl   <= 1'b0;
    end else begin
      sync1 <= q_fb;
      lvl   <= sync1;
    end
  end
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: randomized bench with a cycle-schedule reference model and directed timing checks
module tb_sr_latch_driver;
  localparam int PULSE_W = 4;
  localparam int GUARD_W = 2;
  localparam int TIMEOUT = 16;
  localparam int CHK = PULSE_W + GUARD_W + 1;
`ifdef SR_INIT_CLEAR_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_level = 1'b0;
  logic req_ready, S, R, lvl, busy, done, err, q_fb;
  logic latch = 1'b0, stuck = 1'b0;
  int tests = 0, fails = 0;
  bit m_act, m_init, m_level, m_q, m_s1, nxt_lvl, acc;
  int m_t;
  bit e_s, e_r, e_busy, e_done, e_err, e_ready, e_lvl;

  sr_latch_driver #(.PULSE_W(PULSE_W), .GUARD_W(GUARD_W), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_level(req_level), .req_ready(req_ready),
    .S(S), .R(R), .q_fb(q_fb), .lvl(lvl), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ideal NOR latch, optionally stuck low
  always @(S or R) if (S) latch = 1'b1; else if (R) latch = 1'b0;
  assign q_fb = stuck ? 1'b0 : latch;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: each write is a schedule of cycles 1..N counted from its accept edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_s1 = 0; m_init = INIT; acc = 0;
      e_s = 0; e_r = 0; e_busy = 0; e_done = 0; e_err = 0; e_ready = 0; e_lvl = 0;
    end else begin
      nxt_lvl = m_s1;
      m_s1 = stuck ? 1'b0 : m_q;
      e_done = 0; e_err = 0; acc = 0;
      if (m_act) begin
        if (m_t >= CHK && e_lvl == m_level) begin e_done = 1; m_act = 0; end
        else if (m_t == CHK + TIMEOUT) begin e_err = 1; m_act = 0; end
        else m_t++;
      end else if (m_init || (e_ready && req_valid)) begin
        m_act = 1; m_t = 1; m_level = m_init ? 1'b0 : req_level; acc = !m_init; m_init = 0;
      end
      e_lvl = nxt_lvl;
      e_s = m_act && m_t <= PULSE_W && m_level;
      e_r = m_act && m_t <= PULSE_W && !m_level;
      e_busy = m_act;
      e_ready = !m_act;
      if (e_s) m_q = 1; else if (e_r) m_q = 0;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("outputs", {1'b0, S, R, busy, done, err, req_ready, lvl},
            {1'b0, e_s, e_r, e_busy, e_done, e_err, e_ready, e_lvl});
      check("s_and_r", {7'd0, S & R}, 8'd0);
    end
  end

  task automatic wait_end(input string name, input int exp_n, input bit exp_err);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(done || err) && n < 40);
    check({name, "_cycle"}, 8'(n), 8'(exp_n));
    check({name, "_err"}, {7'd0, err}, {7'd0, exp_err});
    check({name, "_done"}, {7'd0, done}, {7'd0, !exp_err});
    check({name, "_ready"}, {7'd0, req_ready}, 8'd1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("ready_wait", {7'd0, req_ready}, 8'd1);
  endtask

  task automatic do_write(input string name, input bit l, input int exp_n, input bit exp_err);
    wait_ready();
    req_valid = 1; req_level = l;
    @(posedge clk);
    #1 req_valid = 0; req_level = !l;
    wait_end(name, exp_n, exp_err);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outs", {1'b0, S, R, busy, done, err, req_ready, lvl}, 8'd0);
`ifdef SR_INIT_CLEAR_EN
    req_valid = 1; req_level = 1;
    rst_n = 1;
    @(posedge clk);
    wait_end("init", 8, 0);
    check("init_lvl", {7'd0, lvl}, 8'd0);
    @(posedge clk);
    #1 req_valid = 0;
    wait_end("held", 8, 0);
    check("held_lvl", {7'd0, lvl}, 8'd1);
`else
    rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", {7'd0, req_ready}, 8'd1);
`endif
    do_write("set", 1, 8, 0);
    check("set_lvl", {7'd0, lvl}, 8'd1);
    do_write("clr", 0, 8, 0);
    check("clr_lvl", {7'd0, lvl}, 8'd0);
    stuck = 1;
    do_write("stuck", 1, 24, 1);
    stuck = 0;
    wait_ready();
    req_valid = 1; req_level = 1;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check("abort_sr", {6'd0, S, R}, 8'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort_quiet", {5'd0, done, err, busy}, 8'd0);
    end
    rst_n = 1;
    do_write("after_abort", 0, 8, 0);
    repeat (3000) begin
      @(negedge clk);
      if (acc) req_valid = 0;
      if (!req_valid && !m_act) stuck = ($urandom_range(0, 7) == 0);
      if (!req_valid && $urandom_range(0, 3) == 0) begin
        req_valid = 1; req_level = 1'($urandom);
      end else if (!req_valid) req_level = 1'($urandom);
    end
    req_valid = 0;
    repeat (30) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
